// File: rtl/sipo_framer_if.sv
// Bundle for the serial ingress, word egress and overflow status of sipo_framer.
// slave is the framer's view; master is the view of whatever drives and drains it.
interface sipo_framer_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                          serial_data;
  logic                          serial_valid;
  logic                          sof;
  logic [DATA_WIDTH-1:0]         parallel_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;
  logic                          frame_err;
  logic                          overflow;
  logic                          ovf_clr;
  logic [CNT_WIDTH-1:0]          drop_count;

  modport slave (
    input  serial_data, serial_valid, sof, out_ready, ovf_clr,
    output parallel_data, out_valid, fifo_level, frame_err, overflow, drop_count
  );

  modport master (
    output serial_data, serial_valid, sof, out_ready, ovf_clr,
    input  parallel_data, out_valid, fifo_level, frame_err, overflow, drop_count
  );
endinterface

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer: assembles qualified bits into words, resyncs on sof,
// and queues completed words in a small FIFO drained by a valid/ready handshake.
module sipo_framer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_ORDER  = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  sipo_framer_if.slave  bus
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [BW-1:0]          r_bit_cnt;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic                   r_frame_err;
  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [LW-1:0]          r_level;
  logic                   r_overflow;
  logic [CNT_WIDTH-1:0]   r_drop_count;

  logic [BW-1:0]          w_idx;
  logic [BW-1:0]          w_pos;
  logic [DATA_WIDTH-1:0]  w_word;
  logic                   w_push_req;
  logic                   w_out_valid;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;

  // sof forces this bit to slot 0, so the in-flight word is built from w_idx, not r_bit_cnt.
  always_comb begin
    w_idx         = bus.sof ? '0 : r_bit_cnt;
    w_pos         = (BIT_ORDER != 0) ? (BW'(DATA_WIDTH - 1) - w_idx) : w_idx;
    w_word        = r_shift;
    w_word[w_pos] = bus.serial_data;
    w_push_req    = bus.serial_valid && (w_idx == BW'(DATA_WIDTH - 1));
  end

  always_comb begin
    w_out_valid = (r_level != '0);
    w_full      = (r_level == LW'(FIFO_DEPTH));
    w_pop       = w_out_valid && bus.out_ready;
    w_push      = w_push_req && (!w_full || w_pop);
    w_drop      = w_push_req && w_full && !w_pop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= bus.serial_valid && bus.sof && (r_bit_cnt != '0);
      if (bus.serial_valid) begin
        r_shift   <= w_word;
        r_bit_cnt <= w_push_req ? '0 : (w_idx + BW'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // A drop in the same cycle as ovf_clr wins: the count restarts at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (bus.ovf_clr)              r_drop_count <= CNT_WIDTH'(1);
      else if (r_drop_count != '1)  r_drop_count <= r_drop_count + CNT_WIDTH'(1);
    end else if (bus.ovf_clr) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  assign bus.parallel_data = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.out_valid     = w_out_valid;
  assign bus.fifo_level    = r_level;
  assign bus.frame_err     = r_frame_err;
  assign bus.overflow      = r_overflow;
  assign bus.drop_count    = r_drop_count;

endmodule
